hilo_mult_unit: RTL and testbench

- Execute-stage multi-cycle multiplier that owns the HI/LO register pair for mult/multu.
- Consumes the decoder's enhilo_EX, regsel_EX and alu_op (signed/unsigned) controls.
- Produces stall_FETCH back to the control unit while a multiply is in flight.
- Drives the mfhi/mflo read data toward writeback.
- Radix-2 shift-add core, fixed latency, sign correction on completion.

---
 rtl/hilo_mult_unit_pkg.sv | 24 ++
 rtl/hilo_mult_unit.sv | 117 +++++++++++
 tb/tb_hilo_mult_unit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_mult_unit_pkg.sv
`default_nettype none
// ============================================================================
// hilo_mult_unit_pkg : shared cpu constants and HI/LO multiplier state type
// Revision: 1.0
// ============================================================================
package hilo_mult_unit_pkg;

    // ALU opcodes the decoder uses for the multiply instructions
    localparam logic [3:0] ALU_MULT  = 4'b0110;
    localparam logic [3:0] ALU_MULTU = 4'b0111;

    // Writeback source select for mfhi/mflo
    localparam logic [1:0] REGSEL_ALU = 2'd0;
    localparam logic [1:0] REGSEL_HI  = 2'd1;
    localparam logic [1:0] REGSEL_LO  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } hilo_state_t;

endpackage : hilo_mult_unit_pkg
`default_nettype wire

// File: rtl/hilo_mult_unit.sv
`default_nettype none
// ============================================================================
// hilo_mult_unit : radix-2 shift-add multiplier owning the HI/LO pair
// Revision: 1.0
// ============================================================================
module hilo_mult_unit
    import hilo_mult_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enhilo_EX,
    input  logic             signed_EX,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [1:0]       regsel_EX,
    output logic             stall_FETCH,
    output logic             done,
    output logic [WIDTH-1:0] hilo_rd,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int                CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]     LAST = CW'(WIDTH - 1);

    hilo_state_t        state_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      count_q;
    logic               neg_q;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic [WIDTH-1:0]   mag_a_d;
    logic [WIDTH-1:0]   mag_b_d;
    logic [WIDTH:0]     sum_d;
    logic [2*WIDTH-1:0] acc_d;
    logic [2*WIDTH-1:0] result_d;

    // Negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude
    always_comb begin
        mag_a_d = (signed_EX && op_a[WIDTH-1]) ? (-op_a) : op_a;
        mag_b_d = (signed_EX && op_b[WIDTH-1]) ? (-op_b) : op_b;
    end

    // Carry out of the upper-half add becomes the top bit after the shift
    always_comb begin
        sum_d    = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        acc_d    = {sum_d, acc_q[WIDTH-1:1]};
        result_d = neg_q ? (-acc_q) : acc_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            neg_q    <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (enhilo_EX) begin
                        mcand_q  <= mag_a_d;
                        mplier_q <= mag_b_d;
                        neg_q    <= signed_EX & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        acc_q    <= '0;
                        count_q  <= '0;
                        state_q  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc_q    <= acc_d;
                    mplier_q <= mplier_q >> 1;
                    count_q  <= count_q + 1'b1;
                    if (count_q == LAST) begin
                        state_q <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    hi_q    <= result_d[2*WIDTH-1:WIDTH];
                    lo_q    <= result_d[WIDTH-1:0];
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        case (regsel_EX)
            REGSEL_HI: hilo_rd = hi_q;
            REGSEL_LO: hilo_rd = lo_q;
            default:   hilo_rd = '0;
        endcase
    end

    assign stall_FETCH = (state_q != ST_IDLE);
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule : hilo_mult_unit
`default_nettype wire

// File: tb/tb_hilo_mult_unit.sv
`default_nettype none
// ============================================================================
// tb_hilo_mult_unit : self-checking bench for the HI/LO multiplier
// Revision: 1.0
// ============================================================================
module tb_hilo_mult_unit;

    localparam int W = 32;

    logic         clk       = 1'b0;
    logic         rst       = 1'b0;
    logic         enhilo_EX = 1'b0;
    logic         signed_EX = 1'b0;
    logic [W-1:0] op_a      = '0;
    logic [W-1:0] op_b      = '0;
    logic [1:0]   regsel_EX = 2'd0;
    logic         stall_FETCH;
    logic         done;
    logic [W-1:0] hilo_rd;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int total = 0;
    int bad   = 0;

    hilo_mult_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .enhilo_EX   (enhilo_EX),
        .signed_EX   (signed_EX),
        .op_a        (op_a),
        .op_b        (op_b),
        .regsel_EX   (regsel_EX),
        .stall_FETCH (stall_FETCH),
        .done        (done),
        .hilo_rd     (hilo_rd),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] ehi;
        logic [W-1:0] elo;
    } vec_t;

    vec_t vecs [7];

    // Full-width product straight from the arithmetic definition
    function automatic logic [63:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic s);
        longint      sa, sb;
        logic [63:0] ua, ub;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Starts a multiply from IDLE and leaves the bench in the done cycle
    task automatic run_mult(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic s, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                            input int inject_at);
        int cyc;
        int dones;
        enhilo_EX = 1'b1;
        op_a      = a;
        op_b      = b;
        signed_EX = s;
        tick;
        enhilo_EX = 1'b0;
        op_a      = $urandom;
        op_b      = $urandom;
        signed_EX = 1'($urandom);
        chk({nm, " stall_rise"}, 64'(stall_FETCH), 64'd1);
        cyc   = 0;
        dones = 0;
        while (stall_FETCH && cyc < 100) begin
            if (cyc == inject_at) begin
                enhilo_EX = 1'b1;
                op_a      = ~a;
                op_b      = b + 1;
                signed_EX = ~s;
            end
            if (done) dones++;
            cyc++;
            tick;
            enhilo_EX = 1'b0;
        end
        chk({nm, " stall_cycles"}, 64'(cyc), 64'd33);
        chk({nm, " early_done"}, 64'(dones), 64'd0);
        chk({nm, " done"}, 64'(done), 64'd1);
        chk({nm, " hi"}, 64'(hi), 64'(ehi));
        chk({nm, " lo"}, 64'(lo), 64'(elo));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0]  p, p2;
        logic [W-1:0] ra, rb, ra2, rb2;
        logic         rs, rs2;
        int           seen;

        vecs[0] = '{32'h0000_0007, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h0000_0001};
        vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000};
        vecs[4] = '{32'h0000_0000, 32'h1234_5678, 1'b0, 32'h0000_0000, 32'h0000_0000};
        vecs[5] = '{32'h8000_0000, 32'h0000_0002, 1'b0, 32'h0000_0001, 32'h0000_0000};
        vecs[6] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 32'h8000_0000};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst stall", 64'(stall_FETCH), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst hi", 64'(hi), 64'd0);
        chk("rst lo", 64'(lo), 64'd0);
        rst = 1'b1;
        tick;

        for (int i = 0; i < 7; i++) begin
            run_mult($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s,
                     vecs[i].ehi, vecs[i].elo, -1);
            tick;
            chk($sformatf("vec%0d done_pulse", i), 64'(done), 64'd0);
        end

        // mfhi / mflo read port after hi=FFFFFFFF lo=80000000
        regsel_EX = 2'd1; #1; chk("rd hi", 64'(hilo_rd), 64'hFFFF_FFFF);
        regsel_EX = 2'd2; #1; chk("rd lo", 64'(hilo_rd), 64'h8000_0000);
        regsel_EX = 2'd0; #1; chk("rd none0", 64'(hilo_rd), 64'd0);
        regsel_EX = 2'd3; #1; chk("rd none3", 64'(hilo_rd), 64'd0);
        regsel_EX = 2'd0;
        tick;

        // Start request during RUN must be dropped
        p = model(32'h0000_1234, 32'h0000_5678, 1'b0);
        run_mult("inject", 32'h0000_1234, 32'h0000_5678, 1'b0, p[63:32], p[31:0], 5);
        tick;
        chk("inject idle", 64'(stall_FETCH), 64'd0);

        // Back-to-back: second start issued in the done cycle
        ra = $urandom; rb = $urandom; rs = 1'($urandom);
        ra2 = $urandom; rb2 = $urandom; rs2 = 1'($urandom);
        p  = model(ra, rb, rs);
        p2 = model(ra2, rb2, rs2);
        run_mult("b2b_first", ra, rb, rs, p[63:32], p[31:0], -1);
        run_mult("b2b_second", ra2, rb2, rs2, p2[63:32], p2[31:0], -1);
        tick;

        // Randomised products against the arithmetic model
        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom);
            if (i % 5 == 1) ra = 32'h8000_0000;
            if (i % 7 == 2) rb = 32'h0;
            p = model(ra, rb, rs);
            run_mult($sformatf("rand%0d", i), ra, rb, rs, p[63:32], p[31:0], -1);
            tick;
        end

        // Asynchronous reset in the middle of RUN
        run_mult("pre_rst", 32'h0000_0007, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, -1);
        tick;
        enhilo_EX = 1'b1;
        op_a      = 32'h0000_0003;
        op_b      = 32'h0000_0005;
        signed_EX = 1'b0;
        tick;
        enhilo_EX = 1'b0;
        repeat (10) tick;
        rst = 1'b0;
        #1;
        chk("midrst stall", 64'(stall_FETCH), 64'd0);
        chk("midrst hi", 64'(hi), 64'd0);
        chk("midrst lo", 64'(lo), 64'd0);
        chk("midrst done", 64'(done), 64'd0);
        tick;
        rst  = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (done || stall_FETCH) seen++;
        end
        chk("midrst no_activity", 64'(seen), 64'd0);
        chk("midrst hi_hold", 64'(hi), 64'd0);

        run_mult("post_rst", vecs[0].a, vecs[0].b, vecs[0].s, vecs[0].ehi, vecs[0].elo, -1);
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_hilo_mult_unit
`default_nettype wire
